fx_div_ctrl: RTL and testbench
==============================

FX_DIV_CTRL -- requirements
Module: fx_div_ctrl

Interface
REQ-001 Parameter W, default 32, data word width in bits.
REQ-002 Parameter F, default 16, fractional bits (QF format).
REQ-003 Parameter TO_CYCLES, default 64, maximum reciprocal wait cycles before timeout.
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 in_valid / in_ready  in / out  1 / 1  upstream handshake.
REQ-007 a_in / b_in  in  W signed each  numerator / denominator, QF.
REQ-008 recip_start  out  1  single-cycle request pulse to the reciprocal unit.
REQ-009 recip_x  out  W  positive QF operand to the reciprocal unit.
REQ-010 recip_done / recip_invalid  in  1 / 1  reciprocal-unit completion pulse and error flag.
REQ-011 recip_inv  in  W  unsigned QF reciprocal, valid while recip_done=1.
REQ-012 out_valid / out_ready  out / in  1 / 1  downstream handshake.
REQ-013 q_out  out  W signed  quotient a/b, QF.
REQ-014 err / sat / timeout  out  1 each  divide error / saturated result / reciprocal timeout.

Function
REQ-015 The controller SHALL implement states IDLE, REQ, WAIT, MUL, OUT.
REQ-016 in_ready SHALL be 1 only in IDLE; a transfer (in_valid&in_ready) SHALL latch a_in, b_in, result sign (sign(a) XOR sign(b)), |a|, |b|.
REQ-017 If latched b=0, the controller SHALL skip REQ/WAIT, go to OUT with q_out=0, err=1, and never pulse recip_start.
REQ-018 Otherwise REQ SHALL assert recip_start for exactly one cycle, then enter WAIT.
REQ-019 recip_x SHALL equal |b| from REQ through the cycle recip_done is sampled, and be held stable throughout.
REQ-020 In WAIT, recip_done=1 SHALL capture recip_inv and recip_invalid and move to MUL; recip_done outside WAIT SHALL be ignored.
REQ-021 MUL SHALL form P = |a| * inv at 2W bits, take M = P >> F (truncation), then apply sign.
REQ-022 If M exceeds 2^(W-1)-1 (positive) or 2^(W-1) (negative), q_out SHALL saturate to the signed max/min and sat=1.
REQ-023 If captured recip_invalid=1, q_out=0, err=1, sat=0.
REQ-024 OUT SHALL hold out_valid=1 and q_out/err/sat/timeout stable until out_ready=1, then return to IDLE.
REQ-025 Latency: accept at cycle 0, recip_start at cycle 1, recip_done at cycle k, out_valid from cycle k+2; b=0 gives out_valid at cycle 1.
REQ-026 A new transfer SHALL be accepted no earlier than the cycle after the OUT handshake.

Reset
REQ-027 rst_n=0 SHALL asynchronously force IDLE, in_ready=1, recip_start=0, recip_x=0, out_valid=0, q_out=0, err=0, sat=0, timeout=0, wait counter=0.
REQ-028 Reset mid-operation SHALL abandon the transaction without output.

Configuration
REQ-029 Macro FX_DIV_TIMEOUT_EN defined: a counter SHALL count WAIT cycles; upon reaching TO_CYCLES without recip_done, go to OUT with q_out=0, err=1, timeout=1.
REQ-030 Macro undefined: no counter; WAIT persists until recip_done; timeout SHALL be tied 0.

Structure
REQ-031 State enum and saturation constants SHALL reside in shared package fx_div_pkg.
REQ-032 Sub-module fx_sat_mul (combinational |a|*inv, shift, sign, saturate) SHALL be instantiated by fx_div_ctrl.

Verification
REQ-033 a=196608 (3.0), b=131072 (2.0), model returns 32768 -> q_out=98304, err=sat=0.
REQ-034 a=-65536 (-1.0), b=262144 (4.0), model returns 16384 -> q_out=-16384.
REQ-035 b=0, a=65536 -> no recip_start, out_valid at cycle 1, q_out=0, err=1.
REQ-036 a=0x7FFF0000, b=16384, model returns 262144 -> q_out=0x7FFFFFFF, sat=1.
REQ-037 FX_DIV_TIMEOUT_EN, model never done -> out_valid after 64 WAIT cycles, timeout=1, err=1; late done ignored.
REQ-038 out_ready low 5 cycles in OUT -> outputs stable, in_ready=0; rst_n pulse in WAIT -> all REQ-027 values.

Source files
------------

// File: rtl/fx_div_pkg.sv
// Shared definitions for the fixed-point divide controller: FSM state
// encoding and the signed saturation limits used by the multiplier stage.
package fx_div_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    MUL  = 3'd3,
    OUT  = 3'd4
  } state_t;

  // Wide enough to hold limits for any practical word width.
  localparam int unsigned LIM_W = 128;

  // Largest positive magnitude representable in a signed w-bit word: 2^(w-1)-1.
  function automatic logic [LIM_W-1:0] pos_limit(input int unsigned w);
    return (LIM_W'(1) << (w - 1)) - LIM_W'(1);
  endfunction

  // Largest negative magnitude representable in a signed w-bit word: 2^(w-1).
  function automatic logic [LIM_W-1:0] neg_limit(input int unsigned w);
    return LIM_W'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/fx_sat_mul.sv
// Combinational |a| * (1/|b|) in QF format: full 2W-bit product, truncating
// shift by F, sign application and saturation to the signed W-bit range.
module fx_sat_mul import fx_div_pkg::*; #(
  parameter int W = 32,
  parameter int F = 16
) (
  input  logic [W-1:0] a_mag,
  input  logic [W-1:0] inv,
  input  logic         neg,
  output logic [W-1:0] q,
  output logic         sat
);

  localparam int PW = 2 * W;
  localparam logic [PW-1:0] POS_LIM = PW'(pos_limit(W));
  localparam logic [PW-1:0] NEG_LIM = PW'(neg_limit(W));
  localparam logic [W-1:0]  Q_MAX   = W'(pos_limit(W));
  localparam logic [W-1:0]  Q_MIN   = W'(neg_limit(W));

  logic [PW-1:0] prod;
  logic [PW-1:0] mag;

  assign prod = PW'(a_mag) * PW'(inv);
  assign mag  = prod >> F;

  // Apply sign to the truncated magnitude, clamping when it leaves the range.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    q   = mag[W-1:0];
    sat = 1'b0;
    if (neg) begin
      if (mag > NEG_LIM) begin
        q   = Q_MIN;
        sat = 1'b1;
      end else begin
        q = W'(0) - mag[W-1:0];
      end
    end else if (mag > POS_LIM) begin
      q   = Q_MAX;
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/fx_div_ctrl.sv
// Fixed-point divider controller: computes a/b as a * (1/b) using an external
// reciprocal unit. Optional reciprocal-wait timeout is enabled by defining
// FX_DIV_TIMEOUT_EN; without it WAIT persists until recip_done.
module fx_div_ctrl import fx_div_pkg::*; #(
  parameter int W         = 32,
  parameter int F         = 16,
  parameter int TO_CYCLES = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  output logic         recip_start,
  output logic [W-1:0] recip_x,
  input  logic         recip_done,
  input  logic         recip_invalid,
  input  logic [W-1:0] recip_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] q_out,
  output logic         err,
  output logic         sat,
  output logic         timeout
);

  state_t       state;
  logic [W-1:0] a_mag;
  logic         neg;
  logic [W-1:0] inv_q;
  logic         inv_bad;
  logic [W-1:0] mul_q;
  logic         mul_sat;

  function automatic logic [W-1:0] mag_of(input logic [W-1:0] v);
    return v[W-1] ? (~v + 1'b1) : v;
  endfunction

`ifdef FX_DIV_TIMEOUT_EN
  localparam int CNT_W = $clog2(TO_CYCLES + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_CYCLES - 1);
  logic             timeout_q;
  logic [CNT_W-1:0] wait_cnt;
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  fx_sat_mul #(.W(W), .F(F)) u_sat_mul (
    .a_mag (a_mag),
    .inv   (inv_q),
    .neg   (neg),
    .q     (mul_q),
    .sat   (mul_sat)
  );

  // Transaction FSM with all handshake and result outputs registered.
  // NOTE: sequential state is updated with <= only, so every branch sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      recip_start <= 1'b0;
      recip_x     <= '0;
      out_valid   <= 1'b0;
      q_out       <= '0;
      err         <= 1'b0;
      sat         <= 1'b0;
      a_mag       <= '0;
      neg         <= 1'b0;
      inv_q       <= '0;
      inv_bad     <= 1'b0;
`ifdef FX_DIV_TIMEOUT_EN
      timeout_q   <= 1'b0;
      wait_cnt    <= '0;
`endif
    end else begin
      recip_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_mag    <= mag_of(a_in);
            neg      <= a_in[W-1] ^ b_in[W-1];
            recip_x  <= mag_of(b_in);
            in_ready <= 1'b0;
`ifdef FX_DIV_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            if (b_in == '0) begin
              // Divide by zero: answer immediately, never bother the reciprocal unit.
              state     <= OUT;
              out_valid <= 1'b1;
              q_out     <= '0;
              err       <= 1'b1;
              sat       <= 1'b0;
            end else begin
              state       <= REQ;
              recip_start <= 1'b1;
            end
          end
        end
        REQ: begin
          state <= WAIT;
`ifdef FX_DIV_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        WAIT: begin
          if (recip_done) begin
            inv_q   <= recip_inv;
            inv_bad <= recip_invalid;
            recip_x <= '0;
            state   <= MUL;
          end
`ifdef FX_DIV_TIMEOUT_EN
          else if (wait_cnt == TO_LAST) begin
            recip_x   <= '0;
            state     <= OUT;
            out_valid <= 1'b1;
            q_out     <= '0;
            err       <= 1'b1;
            sat       <= 1'b0;
            timeout_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        MUL: begin
          state     <= OUT;
          out_valid <= 1'b1;
          if (inv_bad) begin
            q_out <= '0;
            err   <= 1'b1;
            sat   <= 1'b0;
          end else begin
            q_out <= mul_q;
            err   <= 1'b0;
            sat   <= mul_sat;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fx_div_ctrl.sv
// Scoreboard bench for fx_div_ctrl: a driver pushes expected results from a
// plain-arithmetic model, a reciprocal-unit responder answers requests, and a
// monitor pops and compares whenever an output handshake occurs.
module tb_fx_div_ctrl;

  localparam int W  = 32;
  localparam int F  = 16;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a_in;
  logic [W-1:0]  b_in;
  logic          recip_start;
  logic [W-1:0]  recip_x;
  logic          recip_done;
  logic          recip_invalid;
  logic [W-1:0]  recip_inv;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  q_out;
  logic          err;
  logic          sat;
  logic          timeout;

  fx_div_ctrl #(.W(W), .F(F), .TO_CYCLES(TO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .a_in          (a_in),
    .b_in          (b_in),
    .recip_start   (recip_start),
    .recip_x       (recip_x),
    .recip_done    (recip_done),
    .recip_invalid (recip_invalid),
    .recip_inv     (recip_inv),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .q_out         (q_out),
    .err           (err),
    .sat           (sat),
    .timeout       (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q;
    logic        err;
    logic        sat;
    logic        to;
    logic        lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   bp_mode = 2;  // 0 random out_ready, 1 held low, 2 held high

  logic [31:0] cur_inv;
  logic [31:0] cur_bmag;
  bit          cur_invalid;
  bit          cur_never;
  int          cur_delay;
  int          done_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic abort(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  endtask

  function automatic logic [31:0] mag(input logic [31:0] v);
    return v[31] ? 32'(0 - v) : v;
  endfunction

  // Reference: q = sign(a)^sign(b) applied to floor(|a|*inv / 2^F), clamped.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] inv, input bit invalid);
    exp_t e;
    longint unsigned ma, prod, m;
    bit neg;
    e = '{q: 32'd0, err: 1'b0, sat: 1'b0, to: 1'b0, lat: (b != 0)};
    if (b == 0 || invalid) begin
      e.err = 1'b1;
      return e;
    end
    ma   = a[31] ? ((64'd1 << 32) - {32'd0, a}) : {32'd0, a};
    prod = ma * {32'd0, inv};
    m    = prod >> F;
    neg  = a[31] ^ b[31];
    if (!neg && m > 64'h7FFF_FFFF) begin
      e.q = 32'h7FFF_FFFF; e.sat = 1'b1;
    end else if (neg && m > 64'h8000_0000) begin
      e.q = 32'h8000_0000; e.sat = 1'b1;
    end else begin
      e.q = neg ? 32'(64'd0 - m) : 32'(m);
    end
    return e;
  endfunction

  // Reciprocal-unit responder.
  initial begin
    recip_done = 1'b0; recip_inv = '0; recip_invalid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && recip_start) begin
        check("start_b_nonzero", 64'(cur_bmag != 0), 64'd1);
        check("recip_x_at_start", recip_x, cur_bmag);
        if (!cur_never) begin
          for (int i = 0; i <= cur_delay; i++) begin
            @(negedge clk);
            if (i == 0) check("recip_start_pulse", recip_start, 1'b0);
            check("recip_x_stable", recip_x, cur_bmag);
          end
          recip_done = 1'b1; recip_inv = cur_inv; recip_invalid = cur_invalid;
          done_cyc = cyc;
          @(negedge clk);
          recip_done = 1'b0; recip_inv = $urandom; recip_invalid = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  // Downstream backpressure.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (bp_mode)
        0:       out_ready = 1'($urandom_range(0, 1));
        1:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: stability while stalled, latency on first presentation, compare on handshake.
  initial begin
    logic [34:0] held;
    bit pend;
    exp_t e;
    pend = 1'b0; held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          check("hold_valid", out_valid, 1'b1);
          check("hold_outputs", {q_out, err, sat, timeout}, held);
        end
        if (out_valid) begin
          if (!pend) begin
            check("exp_pending", exp_q.size(), 1);
            if (exp_q.size() > 0 && exp_q[0].lat) check("latency_k_plus_2", cyc, done_cyc + 2);
          end
          if (out_ready) begin
            if (exp_q.size() > 0) begin
              e = exp_q.pop_front();
              check("q_out", q_out, e.q);
              check("err", err, e.err);
              check("sat", sat, e.sat);
              check("timeout", timeout, e.to);
            end
            pend = 1'b0;
          end else begin
            pend = 1'b1;
            held = {q_out, err, sat, timeout};
          end
        end else begin
          pend = 1'b0;
        end
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] inv,
                      input bit invalid, input int delay, input bit never,
                      input bit expect_out, input bit exp_to);
    exp_t e;
    int n;
    e = model(a, b, inv, invalid);
    if (exp_to) e = '{q: 32'd0, err: 1'b1, sat: 1'b0, to: 1'b1, lat: 1'b0};
    @(negedge clk);
    a_in = a; b_in = b; in_valid = 1'b1;
    n = 0;
    while (!in_ready) begin
      @(negedge clk);
      n++;
      if (n > 300) abort("in_ready_wait");
    end
    cur_inv = inv; cur_invalid = invalid; cur_delay = delay;
    cur_never = never; cur_bmag = mag(b);
    if (expect_out) exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0; a_in = $urandom; b_in = $urandom;
    check("in_ready_drop", in_ready, 1'b0);
    if (b == 0) begin
      check("b0_out_valid_cyc1", out_valid, 1'b1);
      check("b0_no_start", recip_start, 1'b0);
    end else begin
      check("start_cyc1", recip_start, 1'b1);
      check("no_early_valid", out_valid, 1'b0);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 500) abort("drain");
    end
    @(negedge clk);
  endtask

  task automatic wait_valid(input string name, output int n);
    n = 0;
    while (!out_valid) begin
      @(negedge clk);
      n++;
      if (n > 300) abort(name);
    end
  endtask

  initial begin
    #2_000_000;
    abort("watchdog");
  end

  initial begin
    int n;
    logic [31:0] a, b, inv;
    rst_n = 1'b0; in_valid = 1'b0; a_in = '0; b_in = '0;
    cur_inv = '0; cur_bmag = '0; cur_invalid = 1'b0; cur_never = 1'b1; cur_delay = 0; done_cyc = 0;
    #12;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_outputs", {recip_start, recip_x, out_valid, q_out, err, sat, timeout}, '0);
    @(negedge clk); rst_n = 1'b1;

    // Directed cases.
    bp_mode = 2;
    send(32'd196608, 32'd131072, 32'd32768, 0, 3, 0, 1, 0);
    send(32'hFFFF_0000, 32'd262144, 32'd16384, 0, 0, 0, 1, 0);
    send(32'd65536, 32'd0, 32'd0, 0, 0, 0, 1, 0);
    send(32'h7FFF_0000, 32'd16384, 32'd262144, 0, 2, 0, 1, 0);
    send(32'h8000_0000, 32'd65536, 32'd65536, 0, 1, 0, 1, 0);
    send(32'd327680, 32'd65536, 32'd65536, 1, 1, 0, 1, 0);
    drain();

    // Backpressure: result held with in_ready low while out_ready stays low.
    bp_mode = 1;
    send(32'h0003_0000, 32'hFFFE_0000, 32'h8000, 0, 0, 0, 1, 0);
    wait_valid("bp_wait_valid", n);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_out_valid", out_valid, 1'b1);
    end
    bp_mode = 2;
    drain();

    // Randomized traffic with random backpressure.
    bp_mode = 0;
    for (int i = 0; i < 40; i++) begin
      a = $urandom >> $urandom_range(0, 20);
      if ($urandom_range(0, 1) == 1) a = 32'(0 - a);
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 24));
      if ($urandom_range(0, 1) == 1) b = 32'(0 - b);
      inv = $urandom >> $urandom_range(8, 31);
      send(a, b, inv, ($urandom_range(0, 7) == 0), $urandom_range(0, 20), 0, 1, 0);
    end
    bp_mode = 2;
    drain();

`ifdef FX_DIV_TIMEOUT_EN
    // Reciprocal unit never answers: timeout after TO WAIT cycles, late done ignored.
    send(32'd65536, 32'd65536, 32'd0, 0, 0, 1, 1, 1);
    wait_valid("timeout_wait_valid", n);
    check("timeout_latency", n, TO + 2);
    drain();
    recip_done = 1'b1; recip_inv = 32'h0001_0000; recip_invalid = 1'b0;
    @(negedge clk);
    recip_done = 1'b0;
    check("late_done_no_output", out_valid, 1'b0);
    send(32'd196608, 32'd131072, 32'd32768, 0, 1, 0, 1, 0);
    drain();
`endif

    // Reset while waiting on the reciprocal: transaction abandoned, no output.
    send(32'd65536, 32'd65536, 32'd0, 0, 0, 1, 0, 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 1'b1);
    check("mid_rst_outputs", {recip_start, recip_x, out_valid, q_out, err, sat, timeout}, '0);
    @(negedge clk); rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("no_output_after_rst", out_valid, 1'b0);
    send(32'hFFFF_0000, 32'd262144, 32'd16384, 0, 2, 0, 1, 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
